mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port 256-byte program/data memory between the processor (port 0) and a secondary requester such as a loader or debug port (port 1). It issues at most one memory access per clock, drives the memory's address, strobe and write controls, and returns read data with a per-port valid pulse that matches the memory's one-cycle read latency. Port 0 has fixed priority. A wait counter guarantees that port 1 is never starved.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: memory data width.
- `MAX_WAIT`, default 4, legal range 1..15: number of consecutive denied cycles after which port 1 gets priority.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `req0`  in  1  port 0 request; level, held until granted.
- `addr0`  in  ADDR_W  port 0 address.
- `we0`  in  1  port 0 write enable (1 = write, 0 = read).
- `wdata0`  in  DATA_W  port 0 write data.
- `gnt0`  out  1  port 0 grant, combinational, same cycle as the access.
- `valid0`  out  1  port 0 read data valid; registered.
- `rdata0`  out  DATA_W  port 0 read data; equals `memDataRead`.
- `req1`, `addr1`, `we1`, `wdata1`, `gnt1`, `valid1`, `rdata1`: same as port 0, for port 1.
- `memAddr`  out  ADDR_W  address to memory.
- `memStrobe`  out  1  access enable to memory.
- `memWrite`  out  1  write enable to memory.
- `memDataWrite`  out  DATA_W  write data to memory.
- `memDataRead`  in  DATA_W  memory read data; registered inside memory, valid the cycle after the strobe.

## Operation
- Priority state machine, 2 states, register `boost`.
  - `NORMAL`: if `req0`, grant 0; else if `req1`, grant 1.
  - `BOOST`: if `req1`, grant 1; else if `req0`, grant 0.
- Wait counter `waitCnt`, width 4, saturating at `MAX_WAIT`.
  - At each edge where `req1=1` and `gnt1=0`: increment.
  - At each edge where `gnt1=1` or `req1=0`: clear to 0.
- State transitions:
  - `NORMAL` -> `BOOST` when `waitCnt` (after update) equals `MAX_WAIT`.
  - `BOOST` -> `NORMAL` at the edge where `gnt1=1` or `req1=0`.
- Granted port's signals drive the memory outputs:
  - `memStrobe=1`, `memAddr=addrX`, `memWrite=weX`, `memDataWrite=wdataX`.
- With no grant: `memStrobe=0`, `memWrite=0`, and `memAddr`/`memDataWrite` driven from port 0's inputs.
- Read-return flags:
  - `valid0` is set at the next edge iff `gnt0 & ~we0`.
  - `valid1` is set at the next edge iff `gnt1 & ~we1`.
  - Writes never produce `valid`; a write is complete at the granting edge.
- `rdata0` and `rdata1` are both wired to `memDataRead`. A requester samples its rdata only while its own valid is high.
- At most one of `gnt0`/`gnt1` is high in any cycle; at most one of `valid0`/`valid1` is high in any cycle.

## Timing
- Request accepted in the same cycle it is presented: `req` high with `gnt` high means the access is issued at that rising edge.
- Read latency: 1 cycle. Access granted in cycle n gives `valid` and data in cycle n+1.
- Throughput: one access per cycle, back-to-back. Reads may be pipelined continuously on one port or alternate between ports.
- A requester may change address or deassert `req` in the cycle after its grant.
- Ungranted requests must hold `addr`, `we` and `wdata` stable; the arbiter does not latch them.
- While `resetN=0`:
  - `gnt0`, `gnt1`, `memStrobe`, `memWrite` are forced to 0.
  - `valid0`, `valid1`, `waitCnt` are cleared to 0; state is `NORMAL`.
- Reset asserted with a read in flight: the valid pulse is lost; there is no retry.
- Release of reset: first grant is possible in the first cycle with `resetN=1`.
- Boundary cases:
  - Simultaneous `req0` and `req1` in `NORMAL`: port 0 wins and `waitCnt` increments.
  - `waitCnt` never exceeds `MAX_WAIT`.
  - `MAX_WAIT=1`: port 1 waits at most 1 cycle.
  - Worst-case port 1 wait is `MAX_WAIT` cycles; the grant comes in cycle `MAX_WAIT+1` after the request.

## Test plan
- Reset: `resetN=0` with both reqs high.
  -> all grants, `memStrobe`, `valid0` and `valid1` are 0.
  -> first cycle after release: `gnt0=1`, `memAddr=addr0`.
- Single read: memory preloaded with `mem[0x10]=0xA5`; `req0=1`, `addr0=0x10`, `we0=0` for 1 cycle.
  -> `gnt0=1`, `memStrobe=1` in cycle n.
  -> `valid0=1`, `rdata0=0xA5` in cycle n+1.
  -> `valid1=0` throughout.
- Back-to-back reads: port 0 reads 0x00, 0x01, 0x02 on consecutive cycles.
  -> `valid0` is high for 3 consecutive cycles, each returning the matching byte one cycle late.
- Write then read: port 1 writes 0x3C to 0x20, then reads 0x20.
  -> `memWrite=1` only on the write cycle.
  -> no `valid1` for the write.
  -> `valid1=1`, `rdata1=0x3C` one cycle after the read grant.
- Starvation, `MAX_WAIT=4`: `req0` and `req1` held high continuously.
  -> port 0 is granted 4 cycles, port 1 in cycle 5, then port 0 resumes.
  -> the pattern repeats with period 5.
  -> `gnt0` and `gnt1` are never both high.
- Reset mid-read: grant a port 1 read, then pull `resetN` low before the next edge.
  -> `valid1` stays 0, `waitCnt=0`, state `NORMAL`.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port synchronous memory. Port 0 has fixed priority.
// A saturating wait counter promotes port 1 for one cycle once it has waited MAX_WAIT cycles.
module mem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              we0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              valid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              we1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              valid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memStrobe,
   output logic              memWrite,
   output logic [DATA_W-1:0] memDataWrite,
   input  logic [DATA_W-1:0] memDataRead
);

   typedef enum logic {NORMAL = 1'b0, BOOST = 1'b1} boost_t;

   localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

   boost_t     boost;
   boost_t     boostNext;
   logic [3:0] waitCnt;
   logic [3:0] waitCntNext;

   // Grant selection; grants are gated off while reset is asserted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!resetN) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end else begin
         case (boost)
            BOOST: begin
               if (req1) begin
                  gnt1 = 1'b1;
               end else if (req0) begin
                  gnt0 = 1'b1;
               end else begin
                  gnt0 = 1'b0;
               end
            end
            default: begin
               if (req0) begin
                  gnt0 = 1'b1;
               end else if (req1) begin
                  gnt1 = 1'b1;
               end else begin
                  gnt0 = 1'b0;
               end
            end
         endcase
      end
   end

   // Wait counter and priority state for the next edge.
   always_comb begin
      waitCntNext = 4'd0;
      boostNext   = NORMAL;
      if (req1 && !gnt1) begin
         if (waitCnt >= MAX_W4) begin
            waitCntNext = MAX_W4;
         end else begin
            waitCntNext = waitCnt + 4'd1;
         end
      end else begin
         waitCntNext = 4'd0;
      end
      case (boost)
         NORMAL: begin
            if (waitCntNext == MAX_W4) begin
               boostNext = BOOST;
            end else begin
               boostNext = NORMAL;
            end
         end
         BOOST: begin
            if (gnt1 || !req1) begin
               boostNext = NORMAL;
            end else begin
               boostNext = BOOST;
            end
         end
         default: boostNext = NORMAL;
      endcase
   end

   // Memory-side mux; with no grant the address/data follow port 0.
   always_comb begin
      memStrobe    = gnt0 | gnt1;
      memWrite     = 1'b0;
      memAddr      = addr0;
      memDataWrite = wdata0;
      if (gnt1) begin
         memWrite     = we1;
         memAddr      = addr1;
         memDataWrite = wdata1;
      end else if (gnt0) begin
         memWrite     = we0;
         memAddr      = addr0;
         memDataWrite = wdata0;
      end else begin
         memWrite     = 1'b0;
      end
   end

   // State, wait counter and read-valid flags (valid tracks the memory's one-cycle latency).
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         boost   <= NORMAL;
         waitCnt <= 4'd0;
         valid0  <= 1'b0;
         valid1  <= 1'b0;
      end else begin
         boost   <= boostNext;
         waitCnt <= waitCntNext;
         valid0  <= gnt0 & ~we0;
         valid1  <= gnt1 & ~we1;
      end
   end

   assign rdata0 = memDataRead;
   assign rdata1 = memDataRead;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle reset corner cases,
// and randomized traffic checked against a priority/wait-count reference model.
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int MW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetN;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, valid0, valid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] memAddr;
   logic          memStrobe, memWrite;
   logic [DW-1:0] memDataWrite;
   logic [DW-1:0] memDataRead;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .resetN(resetN),
      .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
      .gnt0(gnt0), .valid0(valid0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
      .gnt1(gnt1), .valid1(valid1), .rdata1(rdata1),
      .memAddr(memAddr), .memStrobe(memStrobe), .memWrite(memWrite),
      .memDataWrite(memDataWrite), .memDataRead(memDataRead)
   );

   // Synchronous single-port memory with one-cycle read latency
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (memStrobe) begin
         if (memWrite) mem[memAddr] <= memDataWrite;
         else          memDataRead  <= mem[memAddr];
      end
   end

   int nPass  = 0;
   int nTotal = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic r0, w0; logic [7:0] a0, d0;
      logic r1, w1; logic [7:0] a1, d1;
      logic eg0, eg1, ew; logic [7:0] ea;
      logic ev0, ev1; logic [7:0] erd;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(logic r0, logic w0, logic [7:0] a0, logic [7:0] d0,
                               logic r1, logic w1, logic [7:0] a1, logic [7:0] d1,
                               logic eg0, logic eg1, logic ew, logic [7:0] ea,
                               logic ev0, logic ev1, logic [7:0] erd);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.eg0 = eg0; v.eg1 = eg1; v.ew = ew; v.ea = ea;
      v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
      return v;
   endfunction

   // Reference model state for the random phase
   int            denied;
   logic          pv0, pv1;
   logic [7:0]    prd;
   logic [7:0]    shadow [256];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h10] = 8'hA5;
      memDataRead = 8'h00;

      // ---- Reset with both requests high ----
      resetN = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33; wdata0 = 8'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h44; wdata1 = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_strobe", memStrobe, 1'b0);
      check("rst_valid0", valid0, 1'b0);
      check("rst_valid1", valid1, 1'b0);
      @(posedge clk); #1 resetN = 1'b1;
      @(negedge clk);
      check("rel_gnt0", gnt0, 1'b1);
      check("rel_gnt1", gnt1, 1'b0);
      check("rel_addr", memAddr, 8'h33);
      @(posedge clk); #1;

      // ---- Directed table: single read, back-to-back, write/read, starvation ----
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,8'h33));
      vecs.push_back(mk(1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h10, 1'b0,1'b0,8'h00));
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,8'hA5));
      vecs.push_back(mk(1'b1,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00));
      vecs.push_back(mk(1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h01, 1'b1,1'b0,8'h00));
      vecs.push_back(mk(1'b1,1'b0,8'h02,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h02, 1'b1,1'b0,8'h01));
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,8'h02));
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'h3C, 1'b0,1'b1,1'b1,8'h20, 1'b0,1'b0,8'h00));
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h00, 1'b0,1'b1,1'b0,8'h20, 1'b0,1'b0,8'h00));
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h3C));
      vecs.push_back(mk(1'b1,1'b0,8'h05,8'h00, 1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,1'b0,8'h05, 1'b0,1'b0,8'h00));
      vecs.push_back(mk(1'b1,1'b0,8'h05,8'h00, 1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,1'b0,8'h05, 1'b1,1'b0,8'h05));
      vecs.push_back(mk(1'b1,1'b0,8'h05,8'h00, 1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,1'b0,8'h05, 1'b1,1'b0,8'h05));
      vecs.push_back(mk(1'b1,1'b0,8'h05,8'h00, 1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,1'b0,8'h05, 1'b1,1'b0,8'h05));
      vecs.push_back(mk(1'b1,1'b0,8'h05,8'h00, 1'b1,1'b0,8'h06,8'h00, 1'b0,1'b1,1'b0,8'h06, 1'b1,1'b0,8'h05));
      vecs.push_back(mk(1'b1,1'b0,8'h05,8'h00, 1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,1'b0,8'h05, 1'b0,1'b1,8'h06));
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,8'h05));

      foreach (vecs[i]) begin
         req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
         req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
         @(negedge clk);
         check($sformatf("tbl%0d_gnt0", i), gnt0, vecs[i].eg0);
         check($sformatf("tbl%0d_gnt1", i), gnt1, vecs[i].eg1);
         check($sformatf("tbl%0d_strobe", i), memStrobe, vecs[i].eg0 | vecs[i].eg1);
         check($sformatf("tbl%0d_write", i), memWrite, vecs[i].ew);
         check($sformatf("tbl%0d_addr", i), memAddr, vecs[i].ea);
         check($sformatf("tbl%0d_valid0", i), valid0, vecs[i].ev0);
         check($sformatf("tbl%0d_valid1", i), valid1, vecs[i].ev1);
         if (vecs[i].ev0)      check($sformatf("tbl%0d_rdata0", i), rdata0, vecs[i].erd);
         else if (vecs[i].ev1) check($sformatf("tbl%0d_rdata1", i), rdata1, vecs[i].erd);
         @(posedge clk); #1;
      end

      // ---- Reset clears a partly-built wait count ----
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h06;
      repeat (2) begin
         @(negedge clk);
         check("pre_rst_gnt0", gnt0, 1'b1);
         @(posedge clk);
      end
      #1 resetN = 1'b0;
      #1 check("rst_waitcnt", dut.waitCnt, 4'd0);
      @(posedge clk); #1 resetN = 1'b1;
      for (int i = 0; i <= MW; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_gnt1_c%0d", i), gnt1, (i == MW) ? 1'b1 : 1'b0);
         @(posedge clk);
      end
      #1;

      // ---- Reset asserted with a port 1 read in flight ----
      req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
      @(negedge clk);
      check("inflight_gnt1", gnt1, 1'b1);
      #1 resetN = 1'b0;
      @(posedge clk); #1;
      check("inflight_valid1", valid1, 1'b0);
      @(negedge clk);
      check("inflight_valid1_hold", valid1, 1'b0);
      check("inflight_gnt1_rst", gnt1, 1'b0);
      @(posedge clk); #1;
      req1 = 1'b0;
      resetN = 1'b1;

      // ---- Randomized traffic against the reference model ----
      for (int i = 0; i < 256; i++) shadow[i] = mem[i];
      denied = 0; pv0 = 1'b0; pv1 = 1'b0; prd = 8'h00;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic eg0, eg1, hold0, hold1;
         logic [7:0] ea, ed;
         hold0 = (cyc > 0) && req0 && !gnt0;
         hold1 = (cyc > 0) && req1 && !gnt1;
         if (!hold0) begin
            req0 = ($urandom_range(0, 3) != 0);
            we0 = ($urandom_range(0, 3) == 0);
            addr0 = 8'($urandom); wdata0 = 8'($urandom);
         end
         if (!hold1) begin
            req1 = ($urandom_range(0, 2) != 0);
            we1 = ($urandom_range(0, 3) == 0);
            addr1 = 8'($urandom); wdata1 = 8'($urandom);
         end
         // Port 1 wins if it has already waited MAX_WAIT cycles or port 0 is idle
         eg1 = req1 && ((denied >= MW) || !req0);
         eg0 = req0 && !eg1;
         ea = eg1 ? addr1 : addr0;
         ed = eg1 ? wdata1 : wdata0;
         @(negedge clk);
         check("rnd_gnt0", gnt0, eg0);
         check("rnd_gnt1", gnt1, eg1);
         check("rnd_strobe", memStrobe, eg0 | eg1);
         check("rnd_write", memWrite, (eg0 & we0) | (eg1 & we1));
         check("rnd_addr", memAddr, ea);
         if ((eg0 & we0) | (eg1 & we1)) check("rnd_wdata", memDataWrite, ed);
         check("rnd_valid0", valid0, pv0);
         check("rnd_valid1", valid1, pv1);
         if (pv0) check("rnd_rdata0", rdata0, prd);
         if (pv1) check("rnd_rdata1", rdata1, prd);
         @(posedge clk);
         if (req1 && !eg1) denied = (denied + 1 > MW) ? MW : denied + 1;
         else              denied = 0;
         pv0 = eg0 && !we0;
         pv1 = eg1 && !we1;
         if ((eg0 | eg1) && !((eg0 & we0) | (eg1 & we1))) prd = shadow[ea];
         if ((eg0 & we0) | (eg1 & we1)) shadow[ea] = ed;
         #1;
      end

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end
endmodule
